pe_result_requant: RTL
======================

# pe_result_requant

Downstream stage of a processing element: watches the PE's accumulator output and result-valid pulse, counts `k_len` valid MAC results to find the end of a dot product, and captures the final accumulator. The S15.16 value is requantized to S5.10 with round-half-up and saturation, then buffered in a small FIFO behind a valid/ready output port. It feeds the next layer's data input in the same S5.10 format the PE consumes.

## Interface
- `ACCUM_WIDTH`, 32, width of PE accumulator (S15.16)
- `OUT_WIDTH`, 16, output width (S5.10)
- `FRAC_SHIFT`, 6, right shift from S15.16 to S5.10
- `CNT_WIDTH`, 8, width of the dot-product length counter
- `FIFO_DEPTH`, 4, output FIFO entries (power of two)

- `clk`  in  1  clock, all logic on rising edge
- `rst`  in  1  reset, asynchronous, active-high
- `start`  in  1  one-cycle pulse; begins a dot-product collection
- `k_len`  in  CNT_WIDTH  number of PE results per dot product, sampled on `start`
- `pe_accum_in`  in  ACCUM_WIDTH  PE accumulator (signed)
- `pe_result_valid_in`  in  1  PE result-valid pulse
- `busy`  out  1  high while not IDLE
- `out_data`  out  OUT_WIDTH  FIFO head, signed S5.10
- `out_valid`  out  1  FIFO not empty
- `out_ready`  in  1  consumer accepts `out_data`
- `sat_flag`  out  1  sticky: a result saturated
- `drop_err`  out  1  sticky: a result was lost to a full FIFO

## Operation
- States: IDLE, COUNT, CAPTURE.
- IDLE: on `start` with `k_len != 0`, latch `k_len` and clear the counter; go to COUNT. A `start` with `k_len == 0` is ignored.
- COUNT: each `pe_result_valid_in` increments the counter. On the valid where the counter equals `k_len-1`, register `pe_accum_in` into the raw register; go to CAPTURE.
- CAPTURE: requantize the raw register, push into the FIFO, return to IDLE.
- `start` outside IDLE is ignored.
- `pe_result_valid_in` in IDLE or CAPTURE is ignored.
- Requant arithmetic:
  - Sign-extend to ACCUM_WIDTH+1 bits and add `1 << (FRAC_SHIFT-1)`.
  - Arithmetic shift right by FRAC_SHIFT.
  - Clamp to [-2^(OUT_WIDTH-1), 2^(OUT_WIDTH-1)-1].
  - Set `sat_flag` whenever the clamp engages.
- FIFO:
  - Push is accepted when not full, or when full with a pop in the same cycle.
  - Otherwise the result is discarded and `drop_err` is set.
  - Pop occurs when `out_valid && out_ready`.
  - Pointers wrap modulo FIFO_DEPTH.
- Sticky flags clear only on `rst`.

## Timing
- Reset values:
  - State IDLE, counter 0, FIFO empty.
  - `busy`=0, `out_valid`=0, `out_data`=0, `sat_flag`=0, `drop_err`=0.
- `rst` mid-operation aborts collection and empties the FIFO immediately (async).
- `busy` rises the cycle after `start` and falls the cycle after CAPTURE.
- Latency: the final valid sampled at edge N → raw register loaded at N, FIFO push at edge N+1, `out_valid`=1 after N+1.
- Back-to-back: a new `start` is accepted in the cycle after CAPTURE (IDLE).
- `out_data` is combinational from the FIFO head, stable while `out_valid && !out_ready`.
- Simultaneous push and pop on an empty FIFO: the push wins, and `out_valid` is high next cycle.

## Structure
- Shared package `pe_array_pkg`:
  - Width constants ACCUM_WIDTH, OUT_WIDTH, FRAC_SHIFT.
  - The requant state enum (IDLE/COUNT/CAPTURE).
  - A requant/saturate function reused by other output stages.
- One sub-module, `sync_fifo`: parameterized width/depth, with push, pop, full, empty, head data. The FSM, counter, and requant stay in the top.

## Test plan
- **Reset/idle:** hold `rst` 2 cycles → all outputs 0. Pulses on `pe_result_valid_in` without `start` → no `out_valid`.
- **K=1 positive:** `start`, `k_len`=1, then one valid with `pe_accum_in`=327680 (5.0) → `out_data`=0x1400, `out_valid` two edges after the valid.
- **K=3 accumulate:** valids with accum 327680, 196608, -131072 → a single output 0xF800 (-2.0). `busy` is low after CAPTURE.
- **Rounding/saturation:**
  - Inputs 32→1, 31→0, -33→-1 (0xFFFF), with `sat_flag` staying 0.
  - Then 0x7FFFFFFF → 0x7FFF and 0x80000000 → 0x8000, with `sat_flag`=1.
- **FIFO full/backpressure:**
  - Hold `out_ready`=0 over 5 K=1 results → 4 buffered, `drop_err`=1. Releasing `out_ready` pops 4 entries in order, then `out_valid`=0.
  - A push and a pop in the same cycle at full → no drop.
- **Mid-operation reset/ignored start:**
  - `start` K=4, 2 valids, then `rst` → IDLE with an empty FIFO.
  - `start` during COUNT → does not restart the counter.
  - `start` with `k_len`=0 → `busy` stays 0.

Source files
------------

// File: rtl/pe_array_pkg.sv
// Shared PE-array definitions: accumulator/output widths, requant FSM states,
// and the S15.16 -> S5.10 round-half-up saturating requantizer.
package pe_array_pkg;

  localparam int ACCUM_WIDTH = 32;
  localparam int OUT_WIDTH   = 16;
  localparam int FRAC_SHIFT  = 6;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COUNT   = 2'd1,
    ST_CAPTURE = 2'd2
  } rq_state_t;

  // Returns {saturated, value}; one guard bit keeps the rounding add from overflowing.
  function automatic logic [OUT_WIDTH:0] requant_sat(input logic [ACCUM_WIDTH-1:0] acc);
    logic signed [ACCUM_WIDTH:0] bias;
    logic signed [ACCUM_WIDTH:0] rounded;
    logic signed [ACCUM_WIDTH:0] shifted;
    logic signed [ACCUM_WIDTH:0] out_max;
    logic signed [ACCUM_WIDTH:0] out_min;
    logic [OUT_WIDTH-1:0]        value;
    logic                        sat;
    bias    = $signed((ACCUM_WIDTH+1)'(1) << (FRAC_SHIFT - 1));
    out_max = $signed(((ACCUM_WIDTH+1)'(1) << (OUT_WIDTH - 1)) - (ACCUM_WIDTH+1)'(1));
    out_min = ~out_max;
    rounded = $signed({acc[ACCUM_WIDTH-1], acc}) + bias;
    shifted = rounded >>> FRAC_SHIFT;
    sat     = 1'b0;
    value   = shifted[OUT_WIDTH-1:0];
    if (shifted > out_max) begin
      sat   = 1'b1;
      value = out_max[OUT_WIDTH-1:0];
    end else if (shifted < out_min) begin
      sat   = 1'b1;
      value = out_min[OUT_WIDTH-1:0];
    end
    return {sat, value};
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Generic synchronous FIFO; write-to-head visibility one cycle after push.
// A push at full is accepted only when paired with a pop; head reads 0 when empty.
module sync_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             push_ok;
  logic             pop_ok;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign pop_ok  = pop && !empty;
  assign push_ok = push && (!full || pop_ok);
  assign head    = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
      case ({push_ok, pop_ok})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/pe_result_requant.sv
// Counts k_len PE results, captures the last accumulator, requantizes to S5.10 and queues it.
// Output valid one edge after capture; results arriving at a full, unpopped FIFO are dropped.
module pe_result_requant
  import pe_array_pkg::*;
#(
  parameter int ACCUM_WIDTH = pe_array_pkg::ACCUM_WIDTH,
  parameter int OUT_WIDTH   = pe_array_pkg::OUT_WIDTH,
  parameter int FRAC_SHIFT  = pe_array_pkg::FRAC_SHIFT,
  parameter int CNT_WIDTH   = 8,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [CNT_WIDTH-1:0]   k_len,
  input  logic [ACCUM_WIDTH-1:0] pe_accum_in,
  input  logic                   pe_result_valid_in,
  output logic                   busy,
  output logic [OUT_WIDTH-1:0]   out_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic                   sat_flag,
  output logic                   drop_err
);

  // The shared requant function is sized by the package constants.
  if (ACCUM_WIDTH != pe_array_pkg::ACCUM_WIDTH || OUT_WIDTH != pe_array_pkg::OUT_WIDTH ||
      FRAC_SHIFT != pe_array_pkg::FRAC_SHIFT) begin : g_width_check
    $error("pe_result_requant widths must match pe_array_pkg");
  end

  rq_state_t              state_q;
  rq_state_t              state_d;
  logic [CNT_WIDTH-1:0]   cnt_q;
  logic [CNT_WIDTH-1:0]   klen_q;
  logic [ACCUM_WIDTH-1:0] raw_q;
  logic                   accept_start;
  logic                   load_raw;
  logic                   push;
  logic                   pop;
  logic                   fifo_full;
  logic                   fifo_empty;
  logic [OUT_WIDTH:0]     rq;

  assign rq        = requant_sat(raw_q);
  assign busy      = (state_q != ST_IDLE);
  assign out_valid = !fifo_empty;
  assign pop       = out_valid && out_ready;

  always_comb begin
    state_d      = state_q;
    accept_start = 1'b0;
    load_raw     = 1'b0;
    push         = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (start && (k_len != '0)) begin
          accept_start = 1'b1;
          state_d      = ST_COUNT;
        end
      end
      ST_COUNT: begin
        if (pe_result_valid_in && (cnt_q == klen_q - CNT_WIDTH'(1))) begin
          load_raw = 1'b1;
          state_d  = ST_CAPTURE;
        end
      end
      ST_CAPTURE: begin
        push    = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      klen_q   <= '0;
      raw_q    <= '0;
      sat_flag <= 1'b0;
      drop_err <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept_start) begin
        klen_q <= k_len;
        cnt_q  <= '0;
      end else if (state_q == ST_COUNT && pe_result_valid_in) begin
        cnt_q <= cnt_q + CNT_WIDTH'(1);
      end
      if (load_raw) raw_q <= pe_accum_in;
      // Saturation is flagged even if the result is later dropped.
      if (push && rq[OUT_WIDTH]) sat_flag <= 1'b1;
      if (push && fifo_full && !pop) drop_err <= 1'b1;
    end
  end

  sync_fifo #(
    .WIDTH (OUT_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_out_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (rq[OUT_WIDTH-1:0]),
    .pop       (pop),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .head      (out_data)
  );

endmodule
